// File: rtl/wb_dp_pkg.sv
// Shared constants and types for the Wishbone add-engine responder: register map,
// CTRL/STATUS field positions and the engine sequencer states.
package wb_dp_pkg;

  localparam logic [11:0] OFS_REG_LO = 12'h000;
  localparam logic [11:0] OFS_REG_HI = 12'h07C;
  localparam logic [11:0] OFS_CTRL   = 12'h100;
  localparam logic [11:0] OFS_STATUS = 12'h104;
  localparam logic [11:0] OFS_RESULT = 12'h108;
  localparam logic [11:0] OFS_IRQEN  = 12'h10C;

  localparam int unsigned CTRL_RS1_LSB   = 0;
  localparam int unsigned CTRL_RS2_LSB   = 5;
  localparam int unsigned CTRL_RD_LSB    = 10;
  localparam int unsigned CTRL_START_BIT = 31;

  localparam int unsigned STATUS_BUSY_BIT    = 0;
  localparam int unsigned STATUS_DONE_BIT    = 1;
  localparam int unsigned STATUS_CARRY_BIT   = 2;
  localparam int unsigned STATUS_OVERRUN_BIT = 3;
  localparam int unsigned IRQEN_BIT          = 0;

  typedef enum logic [2:0] {
    StIdle,
    StOpA,
    StOpB,
    StExec,
    StWb
  } dp_state_e;

endpackage

// File: rtl/wb_datapath_responder_regfile.sv
// NREGS x DW register file: synchronous clear, two combinational read ports and one
// byte-masked write port. Entry 0 is never written, so it always reads zero.
module dp_regfile #(
  parameter int unsigned NREGS = 32,
  parameter int unsigned DW    = 32,
  parameter int unsigned AW    = 5
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [AW-1:0]   raddr_a_i,
  output logic [DW-1:0]   rdata_a_o,
  input  logic [AW-1:0]   raddr_b_i,
  output logic [DW-1:0]   rdata_b_o,
  input  logic            we_i,
  input  logic [AW-1:0]   waddr_i,
  input  logic [DW/8-1:0] wmask_i,
  input  logic [DW-1:0]   wdata_i
);

  logic [DW-1:0] mem_q [NREGS];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q <= '{default: '0};
    end else if (we_i && (waddr_i != '0)) begin
      for (int unsigned b = 0; b < DW / 8; b++) begin
        if (wmask_i[b]) begin
          mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign rdata_a_o = mem_q[raddr_a_i];
  assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/wb_datapath_responder.sv
// Wishbone classic slave exposing a register file and a sequenced rd = rs1 + rs2 engine
// with done/overrun status and a level interrupt.
module wb_datapath_responder
  import wb_dp_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int unsigned NREGS     = 32,
  parameter int unsigned DW        = 32
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            wbs_stb_i,
  input  logic            wbs_cyc_i,
  input  logic            wbs_we_i,
  input  logic [DW/8-1:0] wbs_sel_i,
  input  logic [DW-1:0]   wbs_dat_i,
  input  logic [31:0]     wbs_adr_i,
  output logic            wbs_ack_o,
  output logic [DW-1:0]   wbs_dat_o,
  output logic            irq_o
);

  localparam int unsigned AW = (NREGS > 1) ? $clog2(NREGS) : 1;

  dp_state_e     state_q, state_d;
  logic          ack_q, launch_q, done_q, done_d, overrun_q, overrun_d;
  logic          carry_q, irq_en_q, irq_q;
  logic [DW-1:0] dat_q, op_a_q, op_b_q, result_q, rdata;
  logic [AW-1:0] rs1_q, rs2_q, rd_q;
  logic [DW:0]   sum;

  logic [9:0]    wofs, reg_word;
  logic          hit, req, reg_sel, busy, service, bus_wr, ctrl_wr, launch, overrun_set;
  logic          status_wr, irqen_wr, unused_adr;
  logic          rf_we;
  logic [AW-1:0] rf_raddr_a, rf_waddr, reg_idx;
  logic [DW-1:0] rf_rdata_a, rf_rdata_b, rf_wdata;
  logic [DW/8-1:0] rf_wmask;

  assign unused_adr = ^wbs_adr_i[1:0];
  assign wofs       = wbs_adr_i[11:2];
  assign reg_word   = wofs - OFS_REG_LO[11:2];
  assign reg_idx    = reg_word[AW-1:0];
  assign hit        = wbs_adr_i[31:12] == BASE_ADDR[31:12];
  assign reg_sel    = (reg_word <= (OFS_REG_HI[11:2] - OFS_REG_LO[11:2])) &&
                      (32'(reg_word) < NREGS);
  assign req        = wbs_cyc_i & wbs_stb_i & hit;
  // A launch pending on the ack cycle counts as busy so no bus access can slip in.
  assign busy       = (state_q != StIdle) | launch_q;
  assign service    = req & ~ack_q & ~(reg_sel & busy);
  assign bus_wr     = service & wbs_we_i;
  assign ctrl_wr    = bus_wr & (wofs == OFS_CTRL[11:2]) & wbs_dat_i[CTRL_START_BIT];
  assign launch     = ctrl_wr & ~busy;
  assign overrun_set = ctrl_wr & busy;
  assign status_wr  = bus_wr & (wofs == OFS_STATUS[11:2]);
  assign irqen_wr   = bus_wr & (wofs == OFS_IRQEN[11:2]);
  assign sum        = {1'b0, op_a_q} + {1'b0, op_b_q};

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (launch_q) state_d = StOpA;
      StOpA:   state_d = StOpB;
      StOpB:   state_d = StExec;
      StExec:  state_d = StWb;
      StWb:    state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Set beats a same-cycle write-one-to-clear.
  always_comb begin
    done_d    = done_q;
    overrun_d = overrun_q;
    if (status_wr && wbs_dat_i[STATUS_DONE_BIT])    done_d    = 1'b0;
    if (status_wr && wbs_dat_i[STATUS_OVERRUN_BIT]) overrun_d = 1'b0;
    if (state_q == StExec) done_d    = 1'b1;
    if (overrun_set)       overrun_d = 1'b1;
  end

  always_comb begin
    rdata = '0;
    if (reg_sel) begin
      rdata = rf_rdata_a;
    end else begin
      case (wofs)
        OFS_STATUS[11:2]: begin
          rdata[STATUS_BUSY_BIT]    = state_q != StIdle;
          rdata[STATUS_DONE_BIT]    = done_q;
          rdata[STATUS_CARRY_BIT]   = carry_q;
          rdata[STATUS_OVERRUN_BIT] = overrun_q;
        end
        OFS_RESULT[11:2]: rdata = result_q;
        OFS_IRQEN[11:2]:  rdata[IRQEN_BIT] = irq_en_q;
        default:          rdata = '0;
      endcase
    end
  end

  // Bus REG access stalls while busy, so writeback never collides with a bus write.
  always_comb begin
    rf_raddr_a = launch_q ? rs1_q : reg_idx;
    rf_we      = (state_q == StExec) | (bus_wr & reg_sel);
    rf_waddr   = (state_q == StExec) ? rd_q : reg_idx;
    rf_wmask   = (state_q == StExec) ? '1 : wbs_sel_i;
    rf_wdata   = (state_q == StExec) ? result_q : wbs_dat_i;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= StIdle;
      ack_q     <= 1'b0;
      dat_q     <= '0;
      launch_q  <= 1'b0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      result_q  <= '0;
      carry_q   <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      irq_en_q  <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ack_q     <= service;
      dat_q     <= (service && !wbs_we_i) ? rdata : '0;
      launch_q  <= launch;
      done_q    <= done_d;
      overrun_q <= overrun_d;
      irq_q     <= done_q & irq_en_q;
      if (launch) begin
        rs1_q <= wbs_dat_i[CTRL_RS1_LSB +: AW];
        rs2_q <= wbs_dat_i[CTRL_RS2_LSB +: AW];
        rd_q  <= wbs_dat_i[CTRL_RD_LSB +: AW];
      end
      if (state_q == StIdle && launch_q) op_a_q <= rf_rdata_a;
      if (state_q == StOpA) op_b_q <= rf_rdata_b;
      if (state_q == StOpB) {carry_q, result_q} <= sum;
      if (irqen_wr) irq_en_q <= wbs_dat_i[IRQEN_BIT];
    end
  end

  dp_regfile #(
    .NREGS(NREGS),
    .DW   (DW),
    .AW   (AW)
  ) u_regfile (
    .clk_i    (wb_clk_i),
    .rst_i    (wb_rst_i),
    .raddr_a_i(rf_raddr_a),
    .rdata_a_o(rf_rdata_a),
    .raddr_b_i(rs2_q),
    .rdata_b_o(rf_rdata_b),
    .we_i     (rf_we),
    .waddr_i  (rf_waddr),
    .wmask_i  (rf_wmask),
    .wdata_i  (rf_wdata)
  );

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign irq_o     = irq_q;

endmodule

// File: tb/tb_wb_datapath_responder.sv
// Self-checking bench: read expectations are queued when a read is issued and compared
// when the responder acknowledges it; engine timing is checked against the cycle counter.
module tb_wb_datapath_responder;

  localparam logic [31:0] Base = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat, rdat;
  logic        ack, irq;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned cyc_cnt  = 0;
  int unsigned ack_cnt  = 0;
  logic        ack_prev = 1'b0;

  logic [31:0] exp_q [$];
  string       tag_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  wb_datapath_responder #(
    .BASE_ADDR(Base),
    .NREGS    (32),
    .DW       (32)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wbs_stb_i(stb),
    .wbs_cyc_i(cyc),
    .wbs_we_i (we),
    .wbs_sel_i(sel),
    .wbs_dat_i(wdat),
    .wbs_adr_i(adr),
    .wbs_ack_o(ack),
    .wbs_dat_o(rdat),
    .irq_o    (irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Scoreboard side: every read ack pops one expectation.
  always @(posedge clk) begin
    #1;
    if (ack) begin
      ack_cnt++;
      check("ack_back_to_back", 32'(ack_prev), 32'd0);
      if (!we) begin
        check("read_queue_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check(tag_q.pop_front(), rdat, exp_q.pop_front());
      end
    end
    ack_prev = ack;
  end

  task automatic wb_write(input logic [11:0] ofs, input logic [31:0] data,
                          input logic [3:0] be, output int unsigned t_ack);
    int unsigned n = 0;
    adr = Base | {20'b0, ofs}; wdat = data; sel = be; we = 1'b1; cyc = 1'b1; stb = 1'b1;
    do begin @(negedge clk); n++; end while (!ack && n < 50);
    check("write_ack", 32'(ack), 32'd1);
    t_ack = cyc_cnt;
    cyc = 1'b0; stb = 1'b0;
  endtask

  task automatic wb_read(input logic [11:0] ofs, input logic [31:0] exp, input string tag,
                         output int unsigned t_ack);
    int unsigned n = 0;
    exp_q.push_back(exp); tag_q.push_back(tag);
    adr = Base | {20'b0, ofs}; sel = 4'hF; we = 1'b0; cyc = 1'b1; stb = 1'b1;
    do begin @(negedge clk); n++; end while (!ack && n < 50);
    check({tag, "_ack"}, 32'(ack), 32'd1);
    t_ack = cyc_cnt;
    cyc = 1'b0; stb = 1'b0;
  endtask

  function automatic logic [31:0] ctrl(input int unsigned rd, input int unsigned rs2,
                                       input int unsigned rs1);
    return 32'h8000_0000 | (32'(rd) << 10) | (32'(rs2) << 5) | 32'(rs1);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    int unsigned t, t2, t3, td, k;
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = '0; wdat = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_ack", 32'(ack), 32'd0);
    check("reset_dat", rdat, 32'd0);
    check("reset_irq", 32'(irq), 32'd0);
    wb_read(12'h104, 32'h0, "reset_status", td);

    // Basic add with interrupt timing.
    wb_write(12'h00C, 32'h5, 4'hF, td);
    wb_write(12'h010, 32'h7, 4'hF, td);
    wb_write(12'h10C, 32'h1, 4'hF, td);
    wb_write(12'h100, ctrl(5, 4, 3), 4'hF, t);
    repeat (4) @(negedge clk);
    check("irq_low_at_done", 32'(irq), 32'd0);
    @(negedge clk);
    check("irq_high_after_done", 32'(irq), 32'd1);
    wb_read(12'h014, 32'h0000_000C, "add_reg5", td);
    wb_read(12'h108, 32'h0000_000C, "add_result", td);
    wb_read(12'h104, 32'h2, "add_status", td);
    wb_read(12'h10C, 32'h1, "irqen_read", td);
    wb_read(12'h100, 32'h0, "ctrl_reads_zero", td);
    wb_write(12'h104, 32'h2, 4'hF, td);
    check("irq_held_on_clear_ack", 32'(irq), 32'd1);
    @(negedge clk);
    check("irq_falls_after_clear", 32'(irq), 32'd0);
    wb_read(12'h104, 32'h0, "status_cleared", td);
    wb_write(12'h10C, 32'h0, 4'hF, td);

    // Carry out, rd = 0 discards writeback, REG0 ignores writes, unmapped offsets.
    wb_write(12'h004, 32'hFFFF_FFFF, 4'hF, td);
    wb_write(12'h008, 32'h2, 4'hF, td);
    wb_write(12'h000, 32'h55, 4'hF, td);
    wb_write(12'h100, ctrl(0, 2, 1), 4'hF, td);
    repeat (6) @(negedge clk);
    wb_read(12'h108, 32'h1, "carry_result", td);
    wb_read(12'h104, 32'h6, "carry_status", td);
    wb_read(12'h000, 32'h0, "reg0_zero", td);
    wb_write(12'h104, 32'h2, 4'hF, td);
    wb_read(12'h104, 32'h4, "carry_kept", td);
    wb_write(12'h200, 32'hCAFE, 4'hF, td);
    wb_read(12'h200, 32'h0, "unmapped_zero", td);

    // Byte-lane write.
    wb_write(12'h01C, 32'h1122_3344, 4'hF, td);
    wb_write(12'h01C, 32'h0000_AB00, 4'b0010, td);
    wb_read(12'h01C, 32'h1122_AB44, "byte_write", td);

    // Overrun and stalled REG read.
    wb_write(12'h020, 32'd10, 4'hF, td);
    wb_write(12'h024, 32'd20, 4'hF, td);
    wb_write(12'h100, ctrl(8, 9, 8), 4'hF, t);
    wb_write(12'h100, ctrl(10, 9, 9), 4'hF, t2);
    check("busy_ctrl_latency", t2 - t, 32'd2);
    wb_read(12'h020, 32'd30, "stalled_read", t3);
    check("stalled_read_latency", t3 - t, 32'd6);
    wb_read(12'h028, 32'h0, "ignored_cmd_rd", td);
    wb_read(12'h104, 32'hA, "overrun_status", td);
    wb_write(12'h104, 32'h8, 4'hF, td);
    wb_read(12'h104, 32'h2, "overrun_cleared", td);

    // A REG write abandoned while stalled leaves no trace.
    wb_write(12'h100, ctrl(16, 9, 8), 4'hF, td);
    k = ack_cnt;
    adr = Base | 32'h03C; wdat = 32'hDEAD; sel = 4'hF; we = 1'b1; cyc = 1'b1; stb = 1'b1;
    repeat (3) @(negedge clk);
    cyc = 1'b0; stb = 1'b0;
    check("abandon_no_ack", ack_cnt - k, 32'd0);
    repeat (4) @(negedge clk);
    wb_read(12'h03C, 32'h0, "abandon_no_write", td);
    wb_read(12'h040, 32'd50, "reuse_result", td);
    wb_write(12'h10C, 32'h1, 4'hF, td);
    repeat (2) @(negedge clk);
    check("irq_on_enable", 32'(irq), 32'd1);

    // Reset during EXEC.
    wb_write(12'h02C, 32'd3, 4'hF, td);
    wb_write(12'h030, 32'd4, 4'hF, td);
    wb_write(12'h100, ctrl(13, 12, 11), 4'hF, t);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_dat", rdat, 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    wb_read(12'h034, 32'h0, "rst_no_writeback", td);
    wb_read(12'h02C, 32'h0, "rst_reg_cleared", td);
    wb_read(12'h108, 32'h0, "rst_result", td);
    wb_read(12'h104, 32'h0, "rst_status", td);
    wb_read(12'h10C, 32'h0, "rst_irqen", td);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
